grf_wb_queue: RTL

//   Write-back queue on the producer side of the GRF write port (A3/WD3/WEN/PC).

---
 rtl/grf_wb_queue_if.sv | 56 +++++
 rtl/grf_wb_queue.sv | 124 ++++++++++++
 2 files changed

// File: rtl/grf_wb_queue_if.sv
// rtl/grf_wb_queue_if.sv - producer, GRF and lookup bundle of the write-back queue
//
// Ports (as seen from the queue, modport slave):
//   pipe_valid/pipe_a3/pipe_wd/pipe_pc  in   W-stage write request
//   pipe_ready                          out  queue takes a pipe request this cycle
//   md_valid/md_a3/md_wd/md_pc          in   mult/div write request
//   md_ready                            out  queue takes an md request this cycle
//   grf_wen/grf_a3/grf_wd3/grf_pc       out  head entry towards the GRF write port
//   q_a1/q_a2                           in   D-stage lookup addresses
//   pend1/pend2, pend_wd1/pend_wd2      out  pending-write hit and youngest data
interface grf_wb_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          pipe_valid;
  logic [AW-1:0] pipe_a3;
  logic [DW-1:0] pipe_wd;
  logic [31:0]   pipe_pc;
  logic          pipe_ready;

  logic          md_valid;
  logic [AW-1:0] md_a3;
  logic [DW-1:0] md_wd;
  logic [31:0]   md_pc;
  logic          md_ready;

  logic          grf_wen;
  logic [AW-1:0] grf_a3;
  logic [DW-1:0] grf_wd3;
  logic [31:0]   grf_pc;

  logic [AW-1:0] q_a1;
  logic [AW-1:0] q_a2;
  logic          pend1;
  logic          pend2;
  logic [DW-1:0] pend_wd1;
  logic [DW-1:0] pend_wd2;

  modport master (
    output pipe_valid, pipe_a3, pipe_wd, pipe_pc,
    output md_valid, md_a3, md_wd, md_pc,
    output q_a1, q_a2,
    input  pipe_ready, md_ready,
    input  grf_wen, grf_a3, grf_wd3, grf_pc,
    input  pend1, pend2, pend_wd1, pend_wd2
  );

  modport slave (
    input  pipe_valid, pipe_a3, pipe_wd, pipe_pc,
    input  md_valid, md_a3, md_wd, md_pc,
    input  q_a1, q_a2,
    output pipe_ready, md_ready,
    output grf_wen, grf_a3, grf_wd3, grf_pc,
    output pend1, pend2, pend_wd1, pend_wd2
  );
endinterface

// File: rtl/grf_wb_queue.sv
// rtl/grf_wb_queue.sv - in-order write-back queue merging W-stage and mult/div results into the GRF
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-low reset
//   bus    grf_wb_queue_if.slave
//          two producer request channels (pipe_*, md_*), the GRF write port (grf_*),
//          and the D-stage pending-write lookup (q_a1/q_a2 -> pend1/2, pend_wd1/2)
module grf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  grf_wb_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_LEFT = CW'(DEPTH - 1);

  logic [AW-1:0] a3_mem [DEPTH];
  logic [DW-1:0] wd_mem [DEPTH];
  logic [31:0]   pc_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          deq;
  logic          pipe_enq;
  logic          md_enq;
  logic [1:0]    enq_n;
  logic [PW-1:0] md_slot;

  // Readiness looks only at the registered count: the head leaving this
  // cycle is not credited, which keeps ready free of any GRF-side path.
  assign bus.pipe_ready = (count != FULL);
  assign bus.md_ready   = (count < ONE_LEFT) || ((count == ONE_LEFT) && !bus.pipe_valid);

  // Writes to $0 are accepted (the producer moves on) but never stored.
  assign pipe_enq = bus.pipe_valid && bus.pipe_ready && (bus.pipe_a3 != '0);
  assign md_enq   = bus.md_valid   && bus.md_ready   && (bus.md_a3   != '0);
  assign enq_n    = {1'b0, pipe_enq} + {1'b0, md_enq};

  // The md entry lands behind the pipe entry when both arrive together.
  assign md_slot  = pipe_enq ? (wr_ptr + PW'(1)) : wr_ptr;

  // The GRF never stalls, so the head retires every non-empty cycle.
  assign deq = (count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a3_mem[i] <= '0;
        wd_mem[i] <= '0;
        pc_mem[i] <= '0;
      end
    end else begin
      if (pipe_enq) begin
        a3_mem[wr_ptr] <= bus.pipe_a3;
        wd_mem[wr_ptr] <= bus.pipe_wd;
        pc_mem[wr_ptr] <= bus.pipe_pc;
      end
      if (md_enq) begin
        a3_mem[md_slot] <= bus.md_a3;
        wd_mem[md_slot] <= bus.md_wd;
        pc_mem[md_slot] <= bus.md_pc;
      end
      wr_ptr <= wr_ptr + PW'(enq_n);
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(enq_n) - CW'(deq);
    end
  end

  assign bus.grf_wen = deq;
  assign bus.grf_a3  = deq ? a3_mem[rd_ptr] : '0;
  assign bus.grf_wd3 = deq ? wd_mem[rd_ptr] : '0;
  assign bus.grf_pc  = deq ? pc_mem[rd_ptr] : '0;

  logic          hit1;
  logic          hit2;
  logic [DW-1:0] hit_wd1;
  logic [DW-1:0] hit_wd2;

  // Walk live entries oldest to youngest so the last match wins. The head is
  // included on purpose: it is being written this cycle, and the GRF read
  // bypass would return the same value.
  always_comb begin : lookup
    logic [PW-1:0] idx;
    logic          live;
    hit1    = 1'b0;
    hit2    = 1'b0;
    hit_wd1 = '0;
    hit_wd2 = '0;
    idx     = '0;
    live    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx  = rd_ptr + PW'(i);
      live = (CW'(i) < count);
      if (live && (bus.q_a1 != '0) && (a3_mem[idx] == bus.q_a1)) begin
        hit1    = 1'b1;
        hit_wd1 = wd_mem[idx];
      end
      if (live && (bus.q_a2 != '0) && (a3_mem[idx] == bus.q_a2)) begin
        hit2    = 1'b1;
        hit_wd2 = wd_mem[idx];
      end
    end
  end

  assign bus.pend1    = hit1;
  assign bus.pend2    = hit2;
  assign bus.pend_wd1 = hit_wd1;
  assign bus.pend_wd2 = hit_wd2;

endmodule
